dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer that shares the single-ported `Data_memory` (synchronous write, combinational read, byte addresses, word-indexed by `address[31:2]`) between the core load/store unit (port 0) and a DMA/debug requester (port 1). It accepts at most one single-word request per cycle and drives the memory's `write`, `address` and `write_data` from registers. It captures `Read_data` and returns a per-port response two cycles after acceptance. It also rejects misaligned or out-of-range requests without touching memory.

## Interface
- `DEPTH`, 64: memory size in 32-bit words; legal word index is 0..DEPTH-1.
- `clk` input 1: single clock, all state updates on rising edge.
- `reset` input 1: asynchronous, active-low; clears all state.
- `p0_valid`, `p1_valid` input 1: request present on port n.
- `p0_ready`, `p1_ready` output 1: port n request accepted this cycle (combinational grant).
- `p0_we`, `p1_we` input 1: 1 = write, 0 = read.
- `p0_addr`, `p1_addr` input 32: byte address.
- `p0_wdata`, `p1_wdata` input 32: write data.
- `p0_resp_valid`, `p1_resp_valid` output 1: one-cycle response pulse.
- `p0_resp_err`, `p1_resp_err` output 1: response is an error; qualified by resp_valid.
- `p0_rdata`, `p1_rdata` output 32: read data; held until the port's next response.
- `mem_write` output 1: to `Data_memory` write.
- `mem_address` output 32: to `Data_memory` address.
- `mem_write_data` output 32: to `Data_memory` write_data.
- `mem_read_data` input 32: from `Data_memory` Read_data.

## Operation
- Grant is combinational each cycle. It is given only to a port whose valid is 1.
  - Only one port valid: that port is granted.
  - Both ports valid: round-robin. The port not granted most recently wins.
- Round-robin pointer `last_grant` updates on every accept. Reset value is 1, so port 0 wins the first contention.
- There is no backpressure from memory. Some port is accepted every cycle that any valid is 1.
- On accept (edge ending cycle C0), the following are registered:
  - `mem_address` ← addr.
  - `mem_write_data` ← wdata.
  - `mem_write` ← we & ~err.
  - Access tag: port id, we, err.
- err = (addr[1:0] != 0) | (addr[31:2] >= DEPTH).
  - An erroneous write never asserts `mem_write`.
  - An erroneous read returns rdata = 0.
- Access stage (cycle C1): memory sees the registered request.
  - A write commits at the edge ending C1.
  - A read's `mem_read_data` is captured at that edge into the tagged port's rdata.
- Response stage (cycle C2): the tagged port's resp_valid = 1 for exactly one cycle. resp_err = tag err.
  - Writes also get a response (ack); rdata is unchanged for writes.
- With no accept in a cycle, `mem_write` is 0 in the following cycle. `mem_address` and `mem_write_data` hold their last value.
- Pipeline states per stage: EMPTY / ACCESS (stage 1) and EMPTY / RESP (stage 2). Both stages advance every cycle unconditionally.

## Timing
- Reset values: `mem_write` 0, `mem_address` 0, `mem_write_data` 0, both resp_valid 0, both resp_err 0, both rdata 0, pipeline stages EMPTY, `last_grant` 1.
- `p0_ready` and `p1_ready` are 0 while reset is asserted, regardless of valid.
- Latency: accept in C0 → resp_valid in C2 (2 cycles). Throughput: 1 request per cycle total.
- Back-to-back write then read to the same address (write accepted C0, read accepted C1) → the read returns the new data. The write commits at the end of C1, before the read's access cycle C2.
- Responses return in acceptance order. A port can have two requests in flight.
- A requester must hold valid, we, addr and wdata stable until ready = 1. Ready is never asserted without valid.
- Reset asserted mid-operation: in-flight accesses are discarded and no response is issued. No memory write occurs after reset asserts, because `mem_write` clears asynchronously.
- First edge after reset deasserts: normal accept.

## Test plan
- Single port-0 write of 0xDEADBEEF to address 0x10, then a read of 0x10 → `mem_write` = 1 for one cycle with `mem_address` 0x10. Read resp_valid arrives 2 cycles after accept with p0_rdata 0xDEADBEEF and resp_err 0.
- Both ports hold valid continuously, with 4 reads each → grants alternate 0,1,0,1,… starting with port 0. Each port receives 4 resp_valid pulses, in order.
- Fill memory: port 1 writes random data to every word 0x00..0xFC in consecutive cycles, then port 0 reads them back → all rdata match the model. One response per cycle is sustained.
- Error cases:
  - Write to 0x102 (misaligned) → resp_err 1 and `mem_write` stays 0.
  - Read of 0x100 with DEPTH = 64 (out of range) → resp_err 1 and rdata 0.
- Port 0 write of 0x12345678 to 0x20 accepted in C0, then port 1 read of 0x20 in C1 → p1_rdata = 0x12345678.
- Assert reset one cycle after a write accept → no `mem_write` pulse and no resp_valid. All outputs return to their reset values immediately, and the memory word is unchanged.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-ported data memory between the core
// load/store unit (port 0) and a DMA/debug requester (port 1).
// Requests are granted combinationally with round-robin on contention.
// They then pass through a registered access stage and a response stage,
// so every accepted request gets exactly one response two cycles later.
// Misaligned or out-of-range requests are answered with an error and
// never touch the memory.
module dmem_arbiter #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        p0_valid,
  output logic        p0_ready,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_resp_valid,
  output logic        p0_resp_err,
  output logic [31:0] p0_rdata,

  input  logic        p1_valid,
  output logic        p1_ready,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_resp_valid,
  output logic        p1_resp_err,
  output logic [31:0] p1_rdata,

  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic {
    S1_EMPTY,
    S1_ACCESS
  } s1_state_t;

  typedef enum logic {
    S2_EMPTY,
    S2_RESP
  } s2_state_t;

  // Round-robin pointer: 1 means port 1 was granted most recently.
  logic        last_grant;

  // Request selected by this cycle's grant.
  logic        accept;
  logic        sel_port;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_misaligned;
  logic        sel_out_of_range;
  logic        sel_err;

  // Access stage tag (memory sees the registered request this cycle).
  s1_state_t   s1_state;
  s1_state_t   s1_next;
  logic        s1_port;
  logic        s1_we;
  logic        s1_err;

  // Response stage tag.
  s2_state_t   s2_state;
  s2_state_t   s2_next;
  logic        s2_port;
  logic        s2_err;

  // Read data for the access stage, forced to zero for rejected reads.
  logic [31:0] access_rdata;

  // Combinational grant; nothing is granted while reset is held low.
  always_comb begin
    p0_ready = 1'b0;
    p1_ready = 1'b0;
    if (reset) begin
      if (p0_valid && p1_valid) begin
        if (last_grant) begin
          p0_ready = 1'b1;
        end else begin
          p1_ready = 1'b1;
        end
      end else if (p0_valid) begin
        p0_ready = 1'b1;
      end else if (p1_valid) begin
        p1_ready = 1'b1;
      end
    end
  end

  // Steer the granted port's request and classify it as legal or not.
  always_comb begin
    accept           = p0_ready | p1_ready;
    sel_port         = p1_ready;
    sel_we           = p1_ready ? p1_we    : p0_we;
    sel_addr         = p1_ready ? p1_addr  : p0_addr;
    sel_wdata        = p1_ready ? p1_wdata : p0_wdata;
    sel_misaligned   = |sel_addr[1:0];
    sel_out_of_range = ({2'b00, sel_addr[31:2]} >= DEPTH_W);
    sel_err          = sel_misaligned | sel_out_of_range;
  end

  // Both pipeline stages advance every cycle with no stall condition.
  always_comb begin
    s1_next = accept ? S1_ACCESS : S1_EMPTY;
    s2_next = (s1_state == S1_ACCESS) ? S2_RESP : S2_EMPTY;
  end

  // Round-robin pointer follows whichever port was accepted last.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= sel_port;
    end
  end

  // Register the accepted request towards memory; write only if legal.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_write      <= 1'b0;
      mem_address    <= 32'h0;
      mem_write_data <= 32'h0;
    end else begin
      mem_write <= accept & sel_we & ~sel_err;
      if (accept) begin
        mem_address    <= sel_addr;
        mem_write_data <= sel_wdata;
      end
    end
  end

  // Access stage state register and its tag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_state <= S1_EMPTY;
      s1_port  <= 1'b0;
      s1_we    <= 1'b0;
      s1_err   <= 1'b0;
    end else begin
      s1_state <= s1_next;
      if (accept) begin
        s1_port <= sel_port;
        s1_we   <= sel_we;
        s1_err  <= sel_err;
      end
    end
  end

  // Response stage state register and its tag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_state <= S2_EMPTY;
      s2_port  <= 1'b0;
      s2_err   <= 1'b0;
    end else begin
      s2_state <= s2_next;
      if (s1_state == S1_ACCESS) begin
        s2_port <= s1_port;
        s2_err  <= s1_err;
      end
    end
  end

  // Rejected reads return zero instead of whatever the memory presents.
  always_comb begin
    access_rdata = s1_err ? 32'h0 : mem_read_data;
  end

  // Capture read data into the owning port at the end of the access cycle;
  // writes leave the port's read data untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p0_rdata <= 32'h0;
      p1_rdata <= 32'h0;
    end else if ((s1_state == S1_ACCESS) && !s1_we) begin
      if (s1_port) begin
        p1_rdata <= access_rdata;
      end else begin
        p0_rdata <= access_rdata;
      end
    end
  end

  // One-cycle response pulse routed to the tagged port.
  always_comb begin
    p0_resp_valid = 1'b0;
    p1_resp_valid = 1'b0;
    p0_resp_err   = 1'b0;
    p1_resp_err   = 1'b0;
    if (s2_state == S2_RESP) begin
      if (s2_port) begin
        p1_resp_valid = 1'b1;
        p1_resp_err   = s2_err;
      end else begin
        p0_resp_valid = 1'b1;
        p0_resp_err   = s2_err;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a behavioural
// Data_memory, a reference memory model and per-port response scoreboards.
module tb_dmem_arbiter;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_valid, p0_ready, p0_we, p0_resp_valid, p0_resp_err;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic        p1_valid, p1_ready, p1_we, p1_resp_valid, p1_resp_err;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic        mem_write;
  logic [31:0] mem_address, mem_write_data, mem_read_data;

  // Behavioural Data_memory: synchronous write, combinational read.
  logic [31:0] tb_mem [0:DEPTH-1];

  // Reference model state.
  logic [31:0] ref_mem [0:DEPTH-1];
  logic [31:0] exp_rd0, exp_rd1;
  logic        bench_last;
  logic        exp_g0, exp_g1;
  int          cyc = 0;
  int          resp_cnt0, resp_cnt1;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          due;
  } resp_t;

  resp_t q0[$];
  resp_t q1[$];

  int vectors = 0;
  int miscompares = 0;

  dmem_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_resp_valid(p0_resp_valid),
    .p0_resp_err(p0_resp_err), .p0_rdata(p0_rdata),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_resp_valid(p1_resp_valid),
    .p1_resp_err(p1_resp_err), .p1_rdata(p1_rdata),
    .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_write) tb_mem[mem_address[7:2]] <= mem_write_data;
  end

  assign mem_read_data = tb_mem[mem_address[7:2]];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Drive one cycle of requests and work out the expected grant.
  task automatic apply(input logic v0, input logic w0, input logic [31:0] a0,
                       input logic [31:0] d0, input logic v1, input logic w1,
                       input logic [31:0] a1, input logic [31:0] d1);
    p0_valid = v0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_valid = v1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
    exp_g0 = v0 && (!v1 || bench_last);
    exp_g1 = v1 && !exp_g0;
    #1;
  endtask

  // Push the expected response of the accepted request, clock once, then
  // pop and compare any response the DUT produced.
  task automatic step_cycle();
    resp_t       e;
    logic        we, err;
    logic [31:0] addr, data;
    if (exp_g0 || exp_g1) begin
      we   = exp_g1 ? p1_we    : p0_we;
      addr = exp_g1 ? p1_addr  : p0_addr;
      data = exp_g1 ? p1_wdata : p0_wdata;
      err  = (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(DEPTH));
      if (!we) begin
        if (exp_g1) exp_rd1 = err ? 32'h0 : ref_mem[addr[7:2]];
        else        exp_rd0 = err ? 32'h0 : ref_mem[addr[7:2]];
      end else if (!err) begin
        ref_mem[addr[7:2]] = data;
      end
      e.err   = err;
      e.due   = cyc + 2;
      e.rdata = exp_g1 ? exp_rd1 : exp_rd0;
      if (exp_g1) q1.push_back(e); else q0.push_back(e);
      bench_last = exp_g1;
    end
    @(posedge clk);
    @(negedge clk);
    if (p0_resp_valid) begin
      resp_cnt0++;
      vectors++;
      if (q0.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL p0_unexpected_resp got resp_valid=1 want none");
      end else begin
        e = q0.pop_front();
        if (p0_resp_err !== e.err || p0_rdata !== e.rdata || cyc != e.due) begin
          miscompares++;
          $display("[TB] FAIL p0_resp got err=%0b rdata=%h cyc=%0d want err=%0b rdata=%h cyc=%0d",
                   p0_resp_err, p0_rdata, cyc, e.err, e.rdata, e.due);
        end
      end
    end
    if (p1_resp_valid) begin
      resp_cnt1++;
      vectors++;
      if (q1.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL p1_unexpected_resp got resp_valid=1 want none");
      end else begin
        e = q1.pop_front();
        if (p1_resp_err !== e.err || p1_rdata !== e.rdata || cyc != e.due) begin
          miscompares++;
          $display("[TB] FAIL p1_resp got err=%0b rdata=%h cyc=%0d want err=%0b rdata=%h cyc=%0d",
                   p1_resp_err, p1_rdata, cyc, e.err, e.rdata, e.due);
        end
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      apply(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      step_cycle();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      tb_mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    exp_rd0 = 32'h0; exp_rd1 = 32'h0; bench_last = 1'b1;
    p0_valid = 1'b1; p0_we = 1'b1; p0_addr = 32'h4; p0_wdata = 32'h1;
    p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 32'h8; p1_wdata = 32'h2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (p0_ready !== 1'b0 || p1_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ready got %0b%0b want 00", p0_ready, p1_ready);
    end
    vectors++;
    if (mem_write !== 1'b0 || mem_address !== 32'h0 || mem_write_data !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_mem got we=%0b addr=%h wd=%h want 0 0 0",
               mem_write, mem_address, mem_write_data);
    end
    vectors++;
    if ({p0_resp_valid, p0_resp_err, p1_resp_valid, p1_resp_err} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_resp got %b want 0000",
               {p0_resp_valid, p0_resp_err, p1_resp_valid, p1_resp_err});
    end
    vectors++;
    if (p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_rdata got %h %h want 0 0", p0_rdata, p1_rdata);
    end
    p0_valid = 1'b0; p1_valid = 1'b0;
    reset = 1'b1;
    resp_cnt0 = 0; resp_cnt1 = 0;
    idle_cycles(2);
  endtask

  task automatic test_round_robin();
    int n0, n1;
    n0 = 0; n1 = 0;
    resp_cnt0 = 0; resp_cnt1 = 0;
    for (int i = 0; i < 8; i++) begin
      apply(n0 < 4, 1'b0, 32'(n0 * 4), 32'h0, n1 < 4, 1'b0, 32'(32 + n1 * 4), 32'h0);
      vectors++;
      if (p0_ready !== exp_g0 || p1_ready !== exp_g1) begin
        miscompares++;
        $display("[TB] FAIL rr_grant cycle %0d got %0b%0b want %0b%0b",
                 i, p0_ready, p1_ready, exp_g0, exp_g1);
      end
      if (exp_g0) n0++;
      if (exp_g1) n1++;
      step_cycle();
    end
    idle_cycles(3);
    vectors++;
    if (resp_cnt0 != 4 || resp_cnt1 != 4 || q0.size() != 0 || q1.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL rr_resp_count got %0d %0d want 4 4", resp_cnt0, resp_cnt1);
    end
  endtask

  task automatic test_single_rw();
    apply(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0);
    vectors++;
    if (p0_ready !== 1'b1 || p1_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_write_grant got %0b%0b want 10", p0_ready, p1_ready);
    end
    step_cycle();
    vectors++;
    if (mem_write !== 1'b1 || mem_address !== 32'h10 || mem_write_data !== 32'hDEADBEEF) begin
      miscompares++;
      $display("[TB] FAIL single_write_mem got we=%0b addr=%h wd=%h want 1 10 deadbeef",
               mem_write, mem_address, mem_write_data);
    end
    apply(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    vectors++;
    if (p0_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL single_read_grant got %0b want 1", p0_ready);
    end
    step_cycle();
    vectors++;
    if (mem_write !== 1'b0 || mem_address !== 32'h10) begin
      miscompares++;
      $display("[TB] FAIL single_read_mem got we=%0b addr=%h want 0 10", mem_write, mem_address);
    end
    idle_cycles(3);
    vectors++;
    if (q0.size() != 0 || q1.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL single_drain got %0d %0d pending want 0 0", q0.size(), q1.size());
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      apply(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'(i * 4), $urandom);
      vectors++;
      if (p1_ready !== 1'b1 || p0_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL fill_write_grant word %0d got %0b%0b want 01", i, p0_ready, p1_ready);
      end
      step_cycle();
    end
    for (int i = 0; i < DEPTH; i++) begin
      apply(1'b1, 1'b0, 32'(i * 4), 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      vectors++;
      if (p0_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL fill_read_grant word %0d got %0b want 1", i, p0_ready);
      end
      step_cycle();
    end
    idle_cycles(3);
    vectors++;
    if (q0.size() != 0 || q1.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL fill_drain got %0d %0d pending want 0 0", q0.size(), q1.size());
    end
  endtask

  task automatic test_errors();
    apply(1'b1, 1'b1, 32'h102, 32'hBAD0BAD0, 1'b0, 1'b0, 32'h0, 32'h0);
    step_cycle();
    vectors++;
    if (mem_write !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL misaligned_write_mem got we=%0b want 0", mem_write);
    end
    apply(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step_cycle();
    vectors++;
    if (mem_write !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL oor_read_mem got we=%0b want 0", mem_write);
    end
    apply(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0000_0104, 32'h5555AAAA);
    step_cycle();
    vectors++;
    if (mem_write !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL oor_write_mem got we=%0b want 0", mem_write);
    end
    idle_cycles(3);
    vectors++;
    if (q0.size() != 0 || q1.size() != 0 || p0_rdata !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL err_drain got %0d %0d pending rdata=%h want 0 0 0",
               q0.size(), q1.size(), p0_rdata);
    end
  endtask

  task automatic test_back_to_back();
    apply(1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, 1'b0, 32'h0, 32'h0);
    step_cycle();
    apply(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
    vectors++;
    if (p1_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_read_grant got %0b want 1", p1_ready);
    end
    step_cycle();
    idle_cycles(3);
    vectors++;
    if (p1_rdata !== 32'h12345678 || tb_mem[8] !== 32'h12345678 || q1.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL b2b_rdata got %h mem=%h want 12345678", p1_rdata, tb_mem[8]);
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] old;
    old = ref_mem[12];
    apply(1'b1, 1'b1, 32'h30, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0, 32'h0);
    step_cycle();
    vectors++;
    if (mem_write !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midop_pre_write got we=%0b want 1", mem_write);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (mem_write !== 1'b0 || mem_address !== 32'h0 || mem_write_data !== 32'h0 ||
        p0_ready !== 1'b0 || p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL midop_async_clear got we=%0b addr=%h wd=%h rdy=%0b rd=%h/%h want all 0",
               mem_write, mem_address, mem_write_data, p0_ready, p0_rdata, p1_rdata);
    end
    q0.delete(); q1.delete();
    exp_rd0 = 32'h0; exp_rd1 = 32'h0; bench_last = 1'b1;
    ref_mem[12] = old;
    p0_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (p0_resp_valid !== 1'b0 || p1_resp_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL midop_no_resp got %0b%0b want 00", p0_resp_valid, p1_resp_valid);
      end
    end
    vectors++;
    if (tb_mem[12] !== old) begin
      miscompares++;
      $display("[TB] FAIL midop_mem_unchanged got %h want %h", tb_mem[12], old);
    end
    reset = 1'b1;
    apply(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0);
    vectors++;
    if (p1_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midop_first_accept got %0b want 1", p1_ready);
    end
    step_cycle();
    idle_cycles(3);
    vectors++;
    if (q1.size() != 0 || p1_rdata !== old) begin
      miscompares++;
      $display("[TB] FAIL midop_readback got %h pending=%0d want %h", p1_rdata, q1.size(), old);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_rw();
    test_fill();
    test_errors();
    test_back_to_back();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
